seq_shift_add_multiplier: RTL and testbench

Parametrised sequential unsigned multiplier that computes `WIDTH`×`WIDTH` → `2*WIDTH` products with one shift-and-add step per clock. It replaces the combinational partial-product arrays with a single adder reused over `WIDTH` cycles. A start/busy/done handshake lets the board top level or a controller issue operations. A compile-time option adds two's-complement operation.

---
 rtl/seq_shift_add_multiplier.sv | 126 ++++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: WIDTH x WIDTH -> 2*WIDTH sequential shift-and-add
// multiplier, one partial-product step per clock, start/busy/done handshake.
// Optional macro SEQ_MULT_SIGNED_EN: operands are two's complement; the
// core multiplies magnitudes and the sign is applied to the final result.
module seq_shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH:0]   r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [PW-1:0]    r_product;

  logic [WIDTH:0]   w_sum;
  logic [PW-1:0]    w_raw;
  logic [WIDTH-1:0] w_ld_mcand;
  logic [WIDTH-1:0] w_ld_mplier;
  logic [PW-1:0]    w_result;

  // Conditional add of the multiplicand into the low accumulator half
  always_comb begin
    w_sum = r_acc;
    if (r_mplier[0]) begin
      w_sum = {1'b0, r_acc[WIDTH-1:0]} + {1'b0, r_mcand};
    end
  end

  // {acc, mplier} after this step's shift, truncated to the product width
  assign w_raw = {w_sum, r_mplier[WIDTH-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [PW-1:0]    ONE_P = PW'(1);

  logic r_neg;

  // Magnitudes of the operands; the most negative value maps to 2^(WIDTH-1)
  assign w_ld_mcand  = a[WIDTH-1] ? ((~a) + ONE_W) : a;
  assign w_ld_mplier = b[WIDTH-1] ? ((~b) + ONE_W) : b;
  assign w_result    = r_neg ? ((~w_raw) + ONE_P) : w_raw;

  // Result sign, captured with the operands
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_neg <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_neg <= a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  assign w_ld_mcand  = a;
  assign w_ld_mplier = b;
  assign w_result    = w_raw;
`endif

  // Control FSM and datapath registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= w_ld_mcand;
            r_mplier <= w_ld_mplier;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc    <= {1'b0, w_sum[WIDTH:1]};
          r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
          if (r_cnt == CNT_LAST) begin
            r_product <= w_result;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Randomised bench for seq_shift_add_multiplier: WIDTH=8 and WIDTH=16
// instances checked against a plain-arithmetic product model.
module tb_seq_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start8, start16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy8, done8, busy16, done16;
  logic [15:0] prod8;
  logic [31:0] prod16;

  logic        sel16;
  logic        m_busy, m_done;
  logic [31:0] m_prod;

  int total = 0;
  int bad   = 0;

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  seq_shift_add_multiplier #(.WIDTH(16)) dut16 (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(prod16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    m_busy = sel16 ? busy16 : busy8;
    m_done = sel16 ? done16 : done8;
    m_prod = sel16 ? prod16 : {16'h0, prod8};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference product: integer multiply of the operands' numeric values
  function automatic logic [63:0] model(input int w, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p;
    sx = longint'(x);
    sy = longint'(y);
`ifdef SEQ_MULT_SIGNED_EN
    if (x[w-1]) sx = sx - (longint'(1) << w);
    if (y[w-1]) sy = sy - (longint'(1) << w);
`endif
    p = sx * sy;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic drive(input logic s, input logic [31:0] x, input logic [31:0] y);
    if (sel16) begin
      start16 = s; a16 = x[15:0]; b16 = y[15:0]; start8 = 1'b0;
    end else begin
      start8 = s; a8 = x[7:0]; b8 = y[7:0]; start16 = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!m_done && n < limit) begin
      tick();
      n++;
    end
  endtask

  // One full operation; with noise, start/a/b toggle randomly while busy
  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y, input bit noise);
    int w;
    logic [63:0] exp;
    logic [63:0] prev;
    w    = sel16 ? 16 : 8;
    exp  = model(w, x, y);
    prev = 64'(m_prod);
    drive(1'b1, x, y);
    tick();
    check({tag, ".accept"}, {m_busy, m_done}, 2'b10);
    drive(1'b0, x, y);
    for (int k = 1; k <= w; k++) begin
      if (noise) drive(1'($urandom_range(0, 1)), $urandom, $urandom);
      tick();
      if (k < w) begin
        check({tag, ".run"}, {m_busy, m_done}, 2'b10);
        check({tag, ".hold"}, 64'(m_prod), prev);
      end
    end
    drive(1'b0, x, y);
    check({tag, ".done"}, {m_busy, m_done}, 2'b01);
    check({tag, ".prod"}, 64'(m_prod), exp);
    tick();
    check({tag, ".after"}, {m_busy, m_done}, 2'b00);
    check({tag, ".keep"}, 64'(m_prod), exp);
  endtask

  initial begin
    int n;
    bit seen;
    sel16 = 1'b0;
    rst_n = 1'b0;
    start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    #1;
    check("reset8", {busy8, done8, 16'(prod8)}, 18'h0);
    check("reset16", {busy16, done16, prod16}, 34'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed WIDTH=8 cases
    do_op("max", 32'hFF, 32'hFF, 1'b0);
    do_op("zero", 32'h00, 32'hA5, 1'b0);
    do_op("ident", 32'h01, 32'hA5, 1'b0);
    do_op("ignore", 32'h12, 32'h34, 1'b1);
`ifdef SEQ_MULT_SIGNED_EN
    do_op("neg3x5", 32'hFD, 32'h05, 1'b0);
    check("neg3x5.const", 64'(m_prod), 64'hFFF1);
    do_op("min_min", 32'h80, 32'h80, 1'b0);
    check("min_min.const", 64'(m_prod), 64'h4000);
`else
    do_op("ff_ff_chk", 32'hFF, 32'hFF, 1'b0);
    check("ff_ff.const", 64'(m_prod), 64'hFE01);
`endif

    // Back-to-back with start held high
    drive(1'b1, 32'd3, 32'd5);
    tick();
    drive(1'b1, 32'd7, 32'd9);
    wait_done(20, n);
    check("b2b.first_lat", 64'(n), 64'd8);
    check("b2b.first", 64'(m_prod), model(8, 32'd3, 32'd5));
    tick();
    check("b2b.reaccept", {m_busy, m_done}, 2'b10);
    check("b2b.held", 64'(m_prod), model(8, 32'd3, 32'd5));
    drive(1'b0, 32'd0, 32'd0);
    wait_done(20, n);
    check("b2b.gap", 64'(n + 1), 64'd9);
    check("b2b.second", 64'(m_prod), model(8, 32'd7, 32'd9));
    tick();

    // Reset abort in cycle 4 of an operation
    drive(1'b1, 32'h12, 32'h34);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("abort", {busy8, done8, 16'(prod8)}, 18'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8 || busy8) seen = 1'b1;
    end
    check("abort.quiet", 64'(seen), 64'd0);

    // Random WIDTH=8
    for (int i = 0; i < 20; i++) begin
      do_op("rand8", 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // WIDTH=16 instance
    sel16 = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    do_op("max16", 32'hFFFF, 32'hFFFF, 1'b0);
`ifndef SEQ_MULT_SIGNED_EN
    check("max16.const", 64'(m_prod), 64'hFFFE0001);
`endif
    for (int i = 0; i < 6; i++) begin
      do_op("rand16", 32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
